pe_retry_fifo: RTL and testbench

PE_RETRY_FIFO -- requirements
Module: pe_retry_fifo

---
 rtl/pe_retry_fifo.sv | 74 +++++++
 tb/tb_pe_retry_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_retry_fifo.sv
// pe_retry_fifo: bumps leaf/data of each arriving leaf packet, queues it, and offers it to the
// network from a holding register that retries until the network stops asserting resend.
module pe_retry_fifo #(
    parameter int num_leaves = 256,
    parameter int payload_sz = 43,
    parameter int p_sz = 52,
    parameter int fifo_depth = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic [p_sz-1:0] interface_pe,
    input  logic resend,
    output logic [p_sz-1:0] pe_interface,
    output logic [$clog2(fifo_depth+1)-1:0] fifo_count,
    output logic [15:0] drop_count,
    output logic overflow,
    output logic busy
);
    localparam int L = $clog2(num_leaves);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth + 1);

    if (payload_sz != p_sz - 1 - L || 2 * L + 33 > p_sz || fifo_depth < 2 || fifo_depth > 64
        || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_param_check
        $error("pe_retry_fifo: inconsistent parameters");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state;
    logic [p_sz-1:0] mem [fifo_depth];
    logic [p_sz-1:0] xf;
    logic [AW-1:0] wp, rp;
    logic full, empty, pop, push, drop;

    always_comb begin
        xf = interface_pe;
        xf[p_sz-1] = 1'b1;
        xf[p_sz-2 -: L] = interface_pe[p_sz-2 -: L] + L'(1);
        xf[31:0] = interface_pe[31:0] + 32'd1;
    end

    assign full = fifo_count == CW'(fifo_depth);
    assign empty = fifo_count == '0;
    // A pop frees a slot at the same edge, so a full FIFO still takes the arriving packet.
    assign pop = !empty && (state == IDLE || !resend);
    assign push = interface_pe[p_sz-1] && (!full || pop);
    assign drop = interface_pe[p_sz-1] && full && !pop;
    assign busy = !empty || pe_interface[p_sz-1];

    always_ff @(posedge clk)
        if (push) mem[wp] <= xf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pe_interface <= '0;
            fifo_count <= '0;
            drop_count <= '0;
            overflow <= 1'b0;
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            overflow <= drop;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            state <= (pop || (state == HOLD && resend)) ? HOLD : IDLE;
            if (pop) pe_interface <= mem[rp];
            else if (state == HOLD && !resend) pe_interface <= '0;
        end
    end
endmodule

// File: tb/tb_pe_retry_fifo.sv
// tb_pe_retry_fifo: scenario tasks plus a scoreboard that checks every packet the network accepts.
module tb_pe_retry_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [51:0] interface_pe = '0;
    logic resend = 1'b0;
    logic [51:0] pe_interface;
    logic [3:0] fifo_count;
    logic [15:0] drop_count;
    logic overflow;
    logic busy;

    int tests = 0;
    int failed = 0;
    logic [51:0] q[$];

    pe_retry_fifo dut (
        .clk(clk),
        .reset(reset),
        .interface_pe(interface_pe),
        .resend(resend),
        .pe_interface(pe_interface),
        .fifo_count(fifo_count),
        .drop_count(drop_count),
        .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] mk(input logic [7:0] leaf, input logic [7:0] seq,
                                       input logic [2:0] pt, input logic [31:0] d);
        return {1'b1, leaf, seq, pt, d};
    endfunction

    function automatic logic [51:0] model(input logic [51:0] p);
        logic [7:0] leaf;
        logic [31:0] d;
        leaf = p[50:43] + 8'd1;
        d = p[31:0] + 32'd1;
        return {1'b1, leaf, p[42:35], p[34:32], d};
    endfunction

    function automatic logic [51:0] rnd_pkt();
        return mk(8'($urandom), 8'($urandom), 3'($urandom), $urandom);
    endfunction

    // Whatever is on pe_interface with resend low now is accepted at the coming edge.
    always @(negedge clk) begin
        if (!reset && pe_interface[51] && !resend) begin
            tests++;
            if (q.size() == 0) begin
                failed++;
                $display("FAIL scoreboard: got unexpected packet %h, required none", pe_interface);
            end else begin
                logic [51:0] e;
                e = q.pop_front();
                if (pe_interface !== e) begin
                    failed++;
                    $display("FAIL scoreboard: got %h, required %h", pe_interface, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [51:0] p, input bit keep);
        interface_pe = p;
        if (keep) q.push_back(model(p));
        tick();
        interface_pe = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        tests++;
        if (q.size() != 0 || busy) begin
            failed++;
            $display("FAIL drain: %0d pending, busy %b, required 0 pending and busy 0", q.size(), busy);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if ({pe_interface, fifo_count, drop_count, overflow, busy} !== '0) begin
            failed++;
            $display("FAIL %s: pe_interface %h fifo_count %0d drop_count %0d overflow %b busy %b, required all 0",
                     name, pe_interface, fifo_count, drop_count, overflow, busy);
        end
    endtask

    task automatic test_reset();
        #3;
        check_idle_outputs("reset_before_clock");
        tick();
        check_idle_outputs("reset_held");
        reset = 1'b0;
    endtask

    task automatic test_single();
        send(mk(8'h05, 8'h3C, 3'b000, 32'h0000_00FF), 1'b1);
        tests++;
        if (pe_interface !== '0 || fifo_count !== 4'd1) begin
            failed++;
            $display("FAIL single_push: pe_interface %h fifo_count %0d, required 0 and 1", pe_interface, fifo_count);
        end
        tick();
        tests++;
        if (pe_interface !== mk(8'h06, 8'h3C, 3'b000, 32'h0000_0100) || fifo_count !== 4'd0) begin
            failed++;
            $display("FAIL single_out: pe_interface %h fifo_count %0d, required %h and 0",
                     pe_interface, fifo_count, mk(8'h06, 8'h3C, 3'b000, 32'h0000_0100));
        end
        tick();
        tests++;
        if (pe_interface !== '0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL single_clear: pe_interface %h busy %b, required 0 and 0", pe_interface, busy);
        end
    endtask

    task automatic test_wrap();
        send(mk(8'hFF, 8'h5A, 3'b101, 32'hFFFF_FFFF), 1'b1);
        tick();
        tests++;
        if (pe_interface !== mk(8'h00, 8'h5A, 3'b101, 32'h0000_0000)) begin
            failed++;
            $display("FAIL wrap: got %h, required %h", pe_interface, mk(8'h00, 8'h5A, 3'b101, 32'h0));
        end
        drain();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 20; i++) send(rnd_pkt(), 1'b1);
        tests++;
        if (drop_count !== 16'd0 || fifo_count > 4'd1) begin
            failed++;
            $display("FAIL stream_occupancy: fifo_count %0d drop_count %0d, required <=1 and 0", fifo_count, drop_count);
        end
        drain();
    endtask

    task automatic test_retry();
        logic [51:0] held;
        send(rnd_pkt(), 1'b1);
        resend = 1'b1;
        tick();
        held = pe_interface;
        tests++;
        if (held !== q[0]) begin
            failed++;
            $display("FAIL retry_appear: got %h, required %h", held, q[0]);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (pe_interface !== held || busy !== 1'b1) begin
                failed++;
                $display("FAIL retry_hold%0d: got %h busy %b, required %h busy 1", i, pe_interface, busy, held);
            end
        end
        resend = 1'b0;
        tick();
        tests++;
        if (pe_interface !== '0 || busy !== 1'b0 || q.size() != 0) begin
            failed++;
            $display("FAIL retry_release: got %h busy %b pending %0d, required 0 busy 0 pending 0",
                     pe_interface, busy, q.size());
        end
    endtask

    task automatic test_random_retry();
        int sent = 0;
        while (sent < 8) begin
            logic [51:0] g;
            resend = 1'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                send(rnd_pkt(), 1'b1);
                sent++;
            end else begin
                g[31:0] = $urandom;
                g[51:32] = 20'($urandom);
                g[51] = 1'b0;
                send(g, 1'b0);
            end
        end
        resend = 1'b0;
        drain();
        tests++;
        if (drop_count !== 16'd0) begin
            failed++;
            $display("FAIL random_retry_drops: got %0d, required 0", drop_count);
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        int bubbles = 0;
        resend = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(rnd_pkt(), i < 9);
            if (overflow) pulses++;
        end
        tests++;
        if (fifo_count !== 4'd8 || drop_count !== 16'd1 || pe_interface !== q[0]) begin
            failed++;
            $display("FAIL overflow_state: fifo_count %0d drop_count %0d held %h, required 8, 1, %h",
                     fifo_count, drop_count, pe_interface, q[0]);
        end
        resend = 1'b0;
        send(rnd_pkt(), 1'b1);
        if (overflow) pulses++;
        tests++;
        if (pulses != 1) begin
            failed++;
            $display("FAIL overflow_pulse: got %0d pulses, required 1", pulses);
        end
        tests++;
        if (fifo_count !== 4'd8 || drop_count !== 16'd1) begin
            failed++;
            $display("FAIL full_push_pop: fifo_count %0d drop_count %0d, required 8 and 1", fifo_count, drop_count);
        end
        for (int i = 0; i < 9; i++) begin
            if (!pe_interface[51]) bubbles++;
            if (i < 8) tick();
        end
        tests++;
        if (bubbles != 0) begin
            failed++;
            $display("FAIL back_to_back: got %0d bubbles, required 0", bubbles);
        end
        tick();
        tests++;
        if (pe_interface !== '0 || q.size() != 0) begin
            failed++;
            $display("FAIL overflow_drain: got %h pending %0d, required 0 and 0", pe_interface, q.size());
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        resend = 1'b1;
        for (int i = 0; i < 5; i++) send(rnd_pkt(), 1'b0);
        tests++;
        if (fifo_count !== 4'd4 || !pe_interface[51]) begin
            failed++;
            $display("FAIL reset_mid_setup: fifo_count %0d valid %b, required 4 and 1", fifo_count, pe_interface[51]);
        end
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_async");
        resend = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pe_interface !== '0 || fifo_count !== 4'd0) stale++;
        end
        tests++;
        if (stale != 0) begin
            failed++;
            $display("FAIL reset_mid_stale: got %0d stale cycles, required 0", stale);
        end
        send(rnd_pkt(), 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_stream();
        test_retry();
        test_random_retry();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
